// File: rtl/cpu_led_pwm_if.sv
// Avalon-MM slave register bus for the LED PWM block.
// The CPU side drives the select/strobe/data signals and the block returns readdata.
interface cpu_led_pwm_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/cpu_led_pwm.sv
// LED PWM driver: programmable frame/duty with glitch-free duty updates, an optional
// blink overlay, an output inversion and a registered pin drive.
module cpu_led_pwm (
    input  logic         clk,
    input  logic         reset_n,
    cpu_led_pwm_if.slave bus,
    input  logic         led_en,
    output logic         led_out
);
    typedef struct packed {
        logic invert;
        logic blink_en;
        logic enable;
    } ctrl_t;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PERIOD = 2'd1;
    localparam logic [1:0] A_DUTY   = 2'd2;
    localparam logic [1:0] A_BLINK  = 2'd3;

    ctrl_t       ctrl;
    logic [15:0] period, duty_shadow, duty_active, pwm_cnt;
    logic [23:0] blink, blink_cnt;
    logic        blink_phase, duty_pending;

    logic wr, wr_ctrl, wr_period, wr_duty, wr_blink;
    logic pwm_wrap, duty_commit, blink_wrap, pwm_raw, led_on;
    logic unused_wd;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wr_ctrl   = wr & (bus.address == A_CTRL);
    assign wr_period = wr & (bus.address == A_PERIOD);
    assign wr_duty   = wr & (bus.address == A_DUTY);
    assign wr_blink  = wr & (bus.address == A_BLINK);
    assign unused_wd = ^bus.writedata[31:24];

    assign pwm_wrap    = (pwm_cnt == period);
    // Duty only moves at a frame boundary (or while idle) so a frame is never torn.
    assign duty_commit = wr_period | ~ctrl.enable | pwm_wrap;
    assign blink_wrap  = (blink_cnt == blink);
    assign pwm_raw     = (pwm_cnt < duty_active);
    assign led_on      = ctrl.enable & led_en & pwm_raw & (~ctrl.blink_en | blink_phase);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl        <= '0;
            period      <= 16'd999;
            duty_shadow <= '0;
            blink       <= '0;
        end else begin
            if (wr_ctrl)   ctrl        <= bus.writedata[2:0];
            if (wr_period) period      <= bus.writedata[15:0];
            if (wr_duty)   duty_shadow <= bus.writedata[15:0];
            if (wr_blink)  blink       <= bus.writedata[23:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt      <= '0;
            duty_active  <= '0;
            duty_pending <= 1'b0;
        end else begin
            if (wr_period || !ctrl.enable || pwm_wrap) pwm_cnt <= '0;
            else                                       pwm_cnt <= pwm_cnt + 16'd1;
            if (duty_commit) duty_active <= duty_shadow;
            // A write landing on the commit edge is still outstanding afterwards.
            if (wr_duty)          duty_pending <= 1'b1;
            else if (duty_commit) duty_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (!ctrl.blink_en) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (wr_blink) begin
            blink_cnt   <= '0;
        end else if (blink_wrap) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 24'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) led_out <= 1'b0;
        else          led_out <= led_on ^ ctrl.invert;
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            A_CTRL:   bus.readdata = {22'd0, duty_pending, blink_phase, 5'd0,
                                      ctrl.invert, ctrl.blink_en, ctrl.enable};
            A_PERIOD: bus.readdata = {16'd0, period};
            A_DUTY:   bus.readdata = {16'd0, duty_shadow};
            A_BLINK:  bus.readdata = {8'd0, blink};
            default:  bus.readdata = '0;
        endcase
    end
endmodule

// File: tb/tb_cpu_led_pwm.sv
// Self-checking bench for cpu_led_pwm: frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed pin/register expectations.
module tb_cpu_led_pwm;
    logic clk = 1'b0;
    logic reset_n;
    logic led_en;
    logic led_out;
    bit   mon_en = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    cpu_led_pwm_if bus();

    cpu_led_pwm dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .led_en  (led_en),
        .led_out (led_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int en, ben, inv;
        int period, dsh, dact, blink;
        int pos, bpos, phase, pend, led;
    } mst_t;

    mst_t m;

    function automatic mst_t reset_state();
        mst_t s;
        s.en = 0; s.ben = 0; s.inv = 0;
        s.period = 999; s.dsh = 0; s.dact = 0; s.blink = 0;
        s.pos = 0; s.bpos = 0; s.phase = 1; s.pend = 0; s.led = 0;
        return s;
    endfunction

    // Frame position advances modulo (PERIOD+1); blink position modulo (BLINK+1).
    function automatic mst_t step(mst_t s, bit w, int a, logic [31:0] d, bit le);
        mst_t n = s;
        bit   commit;
        bit   lit;
        lit   = (s.en != 0) && le && (s.pos < s.dact) && ((s.ben == 0) || (s.phase != 0));
        n.led = (lit ? 1 : 0) ^ s.inv;
        n.pos = (s.en != 0) ? (s.pos + 1) % (s.period + 1) : 0;
        commit = (s.en == 0) || (s.pos == s.period);
        if (s.ben != 0) begin
            n.bpos = (s.bpos + 1) % (s.blink + 1);
            if (s.bpos == s.blink) n.phase = 1 - s.phase;
        end else begin
            n.bpos  = 0;
            n.phase = 1;
        end
        if (w) begin
            case (a)
                0: begin n.en = int'(d[0]); n.ben = int'(d[1]); n.inv = int'(d[2]); end
                1: begin n.period = int'(d[15:0]); n.pos = 0; commit = 1; end
                2: n.dsh = int'(d[15:0]);
                default: begin
                    n.blink = int'(d[23:0]);
                    if (s.ben != 0) begin n.bpos = 0; n.phase = s.phase; end
                end
            endcase
        end
        if (commit) begin n.dact = s.dsh; n.pend = 0; end
        if (w && a == 2) n.pend = 1;
        return n;
    endfunction

    function automatic logic [31:0] mread(mst_t s, logic [1:0] a);
        case (a)
            2'd0:    return 32'(s.en) | (32'(s.ben) << 1) | (32'(s.inv) << 2)
                          | (32'(s.phase) << 8) | (32'(s.pend) << 9);
            2'd1:    return 32'(s.period);
            2'd2:    return 32'(s.dsh);
            default: return 32'(s.blink);
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= reset_state();
        else m <= step(m, bus.chipselect && !bus.write_n, int'(bus.address), bus.writedata, led_en);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (mon_en && reset_n) begin
            chk("model_led_out", 32'(led_out), 32'(m.led));
            chk("model_readdata", bus.readdata, mread(m, bus.address));
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
        #1;
        chk(nm, bus.readdata, exp);
        bus.chipselect = 1'b0;
    endtask

    task automatic wait_pos(input int p);
        int n = 0;
        while (m.pos != p && n < 3000) begin @(negedge clk); n++; end
        if (m.pos != p) chk("wait_pos_timeout", 32'(m.pos), 32'(p));
    endtask

    task automatic count_high(input int len, output int c);
        c = 0;
        repeat (len) begin c += int'(led_out); @(negedge clk); end
    endtask

    task automatic run_len(input logic v, output int c);
        c = 0;
        while (led_out == v && c < 200) begin c++; @(negedge clk); end
    endtask

    initial begin
        int c;
        int n;
        reset_n = 1'b0; led_en = 1'b1;
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        repeat (3) @(negedge clk);
        chk("reset_led_out", 32'(led_out), 32'd0);
        rd(2'd0, 32'h100, "reset_ctrl");
        rd(2'd1, 32'd999, "reset_period");
        rd(2'd2, 32'd0, "reset_duty");
        rd(2'd3, 32'd0, "reset_blink");
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(negedge clk);

        // 3-of-10 frame, first high one cycle after enable
        wr(2'd1, 32'hFFFF_0009);
        wr(2'd2, 32'd3);
        wr(2'd0, 32'd1);
        chk("enable_edge_led", 32'(led_out), 32'd0);
        @(negedge clk);
        chk("first_high", 32'(led_out), 32'd1);
        count_high(30, c);
        chk("duty3_highs_30", 32'(c), 32'd9);

        // duty rewrite mid-frame
        wait_pos(5);
        wr(2'd2, 32'd7);
        rd(2'd0, 32'h301, "pending_set");
        wait_pos(1);
        rd(2'd0, 32'h101, "pending_clear");
        count_high(10, c);
        chk("duty7_frame", 32'(c), 32'd7);

        // duty extremes, with and without invert
        wr(2'd2, 32'd0);   repeat (12) @(negedge clk);
        count_high(20, c); chk("duty0_const0", 32'(c), 32'd0);
        wr(2'd2, 32'd10);  repeat (12) @(negedge clk);
        count_high(20, c); chk("duty10_const1", 32'(c), 32'd20);
        wr(2'd0, 32'd5);   repeat (2) @(negedge clk);
        count_high(20, c); chk("inv_duty10", 32'(c), 32'd0);
        wr(2'd2, 32'd0);   repeat (12) @(negedge clk);
        count_high(20, c); chk("inv_duty0", 32'(c), 32'd20);

        // led_en gating and PERIOD write at wrap
        wr(2'd0, 32'd1);
        wr(2'd2, 32'd7);   repeat (12) @(negedge clk);
        wait_pos(2);
        led_en = 1'b0;
        @(negedge clk);
        chk("led_en_gate", 32'(led_out), 32'd0);
        led_en = 1'b1;
        @(negedge clk);
        chk("led_en_restore", 32'(led_out), 32'd1);
        wait_pos(5);
        wr(2'd2, 32'd2);
        wait_pos(9);
        wr(2'd1, 32'd4);
        rd(2'd0, 32'h101, "period_wr_commit");
        count_high(10, c);
        chk("period4_duty2", 32'(c), 32'd4);

        // blink overlay 50/50
        wr(2'd2, 32'd1);
        wr(2'd1, 32'd0);
        wr(2'd3, 32'd49);
        wr(2'd0, 32'd3);
        n = 0;
        while (led_out != 1'b0 && n < 200) begin n++; @(negedge clk); end
        while (led_out != 1'b1 && n < 400) begin n++; @(negedge clk); end
        chk("blink_rise_seen", 32'(led_out), 32'd1);
        rd(2'd0, 32'h103, "blink_phase_hi");
        run_len(1'b1, c); chk("blink_high_run", 32'(c), 32'd50);
        rd(2'd0, 32'h003, "blink_phase_lo");
        run_len(1'b0, c); chk("blink_low_run", 32'(c), 32'd50);

        // reset mid-frame with invert
        wr(2'd0, 32'd5);
        wr(2'd1, 32'd9);
        wr(2'd2, 32'd3);
        repeat (15) @(negedge clk);
        n = 0;
        while (led_out != 1'b1 && n < 20) begin n++; @(negedge clk); end
        chk("pre_reset_led", 32'(led_out), 32'd1);
        #2 reset_n = 1'b0;
        #1 chk("reset_async_led", 32'(led_out), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd0, 32'h100, "post_reset_ctrl");
        rd(2'd1, 32'd999, "post_reset_period");
        rd(2'd2, 32'd0, "post_reset_duty");
        rd(2'd3, 32'd0, "post_reset_blink");
        repeat (3) @(negedge clk);
        chk("post_reset_led", 32'(led_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 300000");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cpu_led_pwm.md
CPU_LED_PWM -- requirements
Module: cpu_led_pwm

Interface
REQ-001 SHALL provide ports: clk  input  1  system clock; all state on rising edge.
REQ-002 SHALL provide ports: reset_n  input  1  asynchronous active-low reset; assertion clears state immediately, release takes effect synchronously to clk.
REQ-003 SHALL provide ports: address  input  2  Avalon-MM slave register select.
REQ-004 SHALL provide ports: chipselect  input  1  slave select.
REQ-005 SHALL provide ports: write_n  input  1  active-low write strobe.
REQ-006 SHALL provide ports: writedata  input  32  write data.
REQ-007 SHALL provide ports: readdata  output  32  read data, zero wait states, combinational on address.
REQ-008 SHALL provide ports: led_en  input  1  gate driven by the upstream LED PIO out_port.
REQ-009 SHALL provide ports: led_out  output  1  registered LED pin drive.
REQ-010 SHALL provide parameters: none; all widths fixed as below.

Function
REQ-011 SHALL decode a write as chipselect=1 and write_n=0; reads have no side effects.
REQ-012 SHALL implement CTRL at address 0: bit0 enable, bit1 blink_en, bit2 invert; read also returns bit8 blink_phase and bit9 duty_pending; other bits read 0.
REQ-013 SHALL implement PERIOD at address 1: 16 bits; PWM frame length = PERIOD+1 cycles.
REQ-014 SHALL implement DUTY at address 2: 16-bit shadow register; reads return the shadow value.
REQ-015 SHALL implement BLINK at address 3: 24 bits; blink half-period = BLINK+1 cycles.
REQ-016 SHALL ignore writedata bits above each register width; reads zero-extend.
REQ-017 SHALL run 16-bit pwm_cnt 0..PERIOD, wrapping to 0 on the cycle after pwm_cnt==PERIOD; PERIOD=0 holds pwm_cnt at 0.
REQ-018 SHALL compute pwm_raw = (pwm_cnt < duty_active); duty_active >= PERIOD+1 gives constant 1, duty_active=0 constant 0.
REQ-019 SHALL copy shadow DUTY to duty_active on the wrap cycle (pwm_cnt==PERIOD) or any cycle enable=0; duty_pending is 1 from a DUTY write until that copy.
REQ-020 SHALL, on a PERIOD write, load pwm_cnt=0 and commit shadow DUTY to duty_active on the same edge; this overrides a coincident wrap.
REQ-021 SHALL run a 24-bit blink_cnt 0..BLINK when blink_en=1, toggling blink_phase on each wrap; blink_en=0 holds blink_cnt=0 and blink_phase=1.
REQ-022 SHALL, on a BLINK write, load blink_cnt=0 without changing blink_phase.
REQ-023 SHALL form led_on = enable & led_en & pwm_raw & (~blink_en | blink_phase).
REQ-024 SHALL register led_out <= led_on ^ invert, one cycle latency from pwm_cnt/blink_phase/led_en to the pin.
REQ-025 SHALL keep pwm_cnt at 0 while enable=0; counting resumes from 0 the cycle after enable is written 1.
REQ-026 SHALL leave counters running when led_en=0; led_en only gates the output.

Reset
REQ-027 SHALL reset CTRL=0, PERIOD=999, DUTY shadow=0, duty_active=0, BLINK=0, pwm_cnt=0, blink_cnt=0, blink_phase=1, duty_pending=0, led_out=0.
REQ-028 SHALL, on reset assertion mid-frame, force led_out=0 within the same cycle irrespective of invert, and restart every frame from REQ-027 values.

Verification
REQ-029 SHALL cover: PERIOD=9, DUTY=3, enable=1, led_en=1 -> led_out high 3 of every 10 cycles, first high one cycle after enable takes effect.
REQ-030 SHALL cover: DUTY rewritten 3->7 mid-frame at pwm_cnt=5 -> current frame stays 3 high, next frame 7 high; duty_pending reads 1 until wrap, then 0.
REQ-031 SHALL cover: DUTY=0 -> led_out constant 0; DUTY=10 with PERIOD=9 -> constant 1; invert=1 inverts both.
REQ-032 SHALL cover: blink_en=1, BLINK=49, PERIOD=0, DUTY=1 -> led_out alternates 50 cycles high, 50 low; blink_phase on CTRL bit8 tracks it.
REQ-033 SHALL cover: led_en toggled 1->0 at pwm_cnt=2 -> led_out 0 the next cycle, pwm_cnt unaffected; PERIOD write at wrap -> pwm_cnt=0 and new DUTY committed.
REQ-034 SHALL cover: reset_n pulsed low mid-frame with invert=1 -> led_out=0 immediately; all registers read REQ-027 values (PERIOD reads 999).
